// File: rtl/muldiv_sequencer.sv
// Multicycle multiply/divide unit. It runs shift-add multiply and restoring
// divide, one iteration per cycle, and leaves the 2*WIDTH-bit result in HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_upper;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Datapath terms: operand magnitudes, one multiply/divide step, sign fix-up.
  always_comb begin
    // op[0]=0 selects the signed variants (MULT, DIV)
    a_neg = ~op_q[0] & a_q[WIDTH-1];
    b_neg = ~op_q[0] & b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;

    // Multiply step: conditional add into the upper half, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               {1'b0, (acc_q[0] ? mcand_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: the shifted-out MSB is kept as bit WIDTH of the partial
    // remainder so the trial subtraction never loses a carry.
    div_upper = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_upper - {1'b0, mcand_q};
    div_next  = div_diff[WIDTH]
              ? {div_upper[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
              : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    prod_fix = res_neg_q ? -acc_q : acc_q;
    quo_fix  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // Multiply: mcand = multiplicand, low half = multiplier.
        // Divide:   mcand = divisor,      low half = dividend.
        mcand_d   = op_q[1] ? b_mag : a_mag;
        acc_d     = {{WIDTH{1'b0}}, (op_q[1] ? a_mag : b_mag)};
        res_neg_d = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        divz_d    = op_q[1] & (b_q == '0);
        cnt_d     = CW'(WIDTH - 1);
        state_d   = S_RUN;
      end
      S_RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        if (divz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) && divz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes model results,
// a monitor pops and compares them whenever done is seen.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  t;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [W-1:0] hold_hi = '0;
  logic [W-1:0] hold_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the MIPS definitions of each op.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, p, q, r;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    e.dz = 1'b0;
    e.t  = 0;
    case (o)
      2'b00: begin
        p = sx * sy;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        up = {32'h0, x} * {32'h0, y};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
        if (y == 0) begin
          e.hi = x;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          e.hi = r[31:0];
          e.lo = q[31:0];
        end else begin
          e.hi = x % y;
          e.lo = x / y;
        end
      end
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic summary_and_die(input string why);
    failures++;
    $display("FAIL %s", why);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench aborted");
  endtask

  // Called on a falling edge; returns on the falling edge of the first IDLE cycle.
  task automatic wait_idle();
    int n = 0;
    while (busy || done) begin
      @(negedge clock);
      n++;
      if (n > 100) summary_and_die("wait_idle timeout");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    @(negedge clock);
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e     = model(o, x, y);
    e.t   = cyc + 1;  // cycle in which start is presented
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (reset) begin
        sb.delete();
        hold_hi = '0;
        hold_lo = '0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div_zero", div_zero, 0);
      end else if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("hi", hi, mon_e.hi);
          check("lo", lo, mon_e.lo);
          check("div_zero", div_zero, mon_e.dz);
          check("latency", cyc + 1 - mon_e.t, W + 3);
          check("busy_in_done", busy, 1);
          hold_hi = mon_e.hi;
          hold_lo = mon_e.lo;
        end
      end else begin
        check("hold_hi", hi, hold_hi);
        check("hold_lo", lo, hold_lo);
        check("div_zero_idle", div_zero, 0);
      end
    end
  end

  // Driver.
  initial begin
    int n;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_hi", hi, 0);
    check("idle_lo", lo, 0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b11, 32'd100, 32'd0);
    issue(2'b10, 32'h8000_0000, 32'd0);

    // A start during RUN cycle 3 must be dropped.
    issue(2'b01, 32'd6, 32'd7);
    repeat (3) @(negedge clock);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
    @(negedge clock);
    start = 1'b0;

    // A start presented in the DONE cycle must also be dropped.
    n = 0;
    while (!done) begin
      @(negedge clock);
      n++;
      if (n > 60) summary_and_die("done_wait timeout");
    end
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    check("start_in_done_ignored_busy", busy, 0);

    // Reset during RUN cycle 10 abandons the operation.
    issue(2'b01, 32'd2, 32'd2);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("post_reset_busy", busy, 0);
    check("post_reset_hi", hi, 0);
    check("post_reset_lo", lo, 0);
    repeat (45) @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
